// File: rtl/braille_pkg.sv
// Shared types and constants for the braille cell driver: dot width, letter
// patterns, FSM state encoding and ASCII letter ranges.
package braille_pkg;

    localparam int unsigned DOT_W = 6;

    typedef logic [DOT_W-1:0] dots_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] ASCII_UPPER_FIRST = 8'h41;
    localparam logic [7:0] ASCII_UPPER_LAST  = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_FIRST = 8'h61;
    localparam logic [7:0] ASCII_LOWER_LAST  = 8'h7A;

    // Grade-1 letters a..z; bit0 = dot1 ... bit5 = dot6.
    localparam dots_t LETTER_DOTS [26] = '{
        6'h01, 6'h03, 6'h09, 6'h19, 6'h11, 6'h0B, 6'h1B, 6'h13, 6'h0A,
        6'h1A, 6'h05, 6'h07, 6'h0D, 6'h1D, 6'h15, 6'h0F, 6'h1F, 6'h17,
        6'h0E, 6'h1E, 6'h25, 6'h27, 6'h3A, 6'h2D, 6'h3D, 6'h35
    };

    function automatic dots_t lookup_dots(input logic [7:0] code);
        dots_t d;
        d = '0;
        if (code >= ASCII_UPPER_FIRST && code <= ASCII_UPPER_LAST) begin
            d = LETTER_DOTS[5'(code - ASCII_UPPER_FIRST)];
        end else if (code >= ASCII_LOWER_FIRST && code <= ASCII_LOWER_LAST) begin
            d = LETTER_DOTS[5'(code - ASCII_LOWER_FIRST)];
        end
        return d;
    endfunction

endpackage

// File: rtl/braille_fifo.sv
// Synchronous first-word-fall-through FIFO for queued character codes.
// DEPTH must be a power of two; pushes while full and pops while empty are ignored.
module braille_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/braille_cell_driver.sv
// Braille cell driver: queues classified characters, shows each as a 6-dot pattern
// for HOLD_CYCLES then blanks for GAP_CYCLES. Optional macro BRAILLE_DROP_CNT_EN adds drop_cnt.
module braille_cell_driver
    import braille_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned GAP_CYCLES  = 10_000_000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       alpha,
    output logic [DOT_W-1:0] dots,
    output logic             busy,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [7:0]                    w_fifo_head;
    logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic                          w_pop;
    dots_t                         w_head_dots;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CNT_W-1:0]              r_cnt;
    logic [CNT_W-1:0]              w_cnt_nxt;
    dots_t                         r_dots;
    dots_t                         w_dots_nxt;
    logic                          r_overflow;

    braille_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (in_valid),
        .push_data (alpha),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign w_head_dots = lookup_dots(w_fifo_head);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dots_nxt  = r_dots;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_dots_nxt  = w_head_dots;
                    w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_dots_nxt  = '0;
                    w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
                    w_state_nxt = GAP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                // Chain straight into the next character so no IDLE cycle is inserted.
                if (r_cnt == '0) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_dots_nxt  = w_head_dots;
                        w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_dots_nxt  = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dots     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dots     <= w_dots_nxt;
            r_overflow <= in_valid && w_fifo_full;
        end
    end

    assign dots     = r_dots;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE) || (w_fifo_count != '0);

`ifdef BRAILLE_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (r_overflow && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_braille_cell_driver.sv
// Scoreboard bench for braille_cell_driver: the driver predicts each character's
// display window from timing rules; a per-cycle monitor pops and compares.
module tb_braille_cell_driver;

    localparam int unsigned H     = 8;
    localparam int unsigned G     = 3;
    localparam int unsigned DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] alpha    = 8'h00;
    logic [5:0] dots;
    logic       busy;
    logic       overflow;
    logic [7:0] drop_cnt;

    braille_cell_driver #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .alpha    (alpha),
        .dots     (dots),
        .busy     (busy),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned accept;
        int unsigned start;
        logic [5:0]  pat;
    } episode_t;

    episode_t    sb_q[$];
    int unsigned ovf_q[$];
    int unsigned last_end   = 0;
    int unsigned exp_drop   = 0;
    int          n_vec      = 0;
    int          n_err      = 0;
    bit          monitor_on = 1'b0;

    // Raised dots of each letter a..z, written as braille dot numbers.
    string DOT_LISTS [26] = '{
        "1", "12", "14", "145", "15", "124", "1245", "125", "24", "245",
        "13", "123", "134", "1345", "135", "1234", "12345", "1235", "234", "2345",
        "136", "1236", "2456", "1346", "13456", "1356"
    };

    function automatic logic [5:0] ref_pattern(input logic [7:0] a);
        int         idx;
        string      s;
        logic [5:0] p;
        idx = -1;
        p   = '0;
        if (a >= 8'h41 && a <= 8'h5A) idx = int'(a) - 'h41;
        if (a >= 8'h61 && a <= 8'h7A) idx = int'(a) - 'h61;
        if (idx >= 0) begin
            s = DOT_LISTS[idx];
            for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 'h31] = 1'b1;
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // A character is in the FIFO from the cycle after acceptance until the cycle
    // before it appears; it appears 2 cycles after acceptance or when the cell frees.
    task automatic model_input(input int unsigned c, input logic [7:0] a);
        int unsigned occ;
        int unsigned st;
        occ = 0;
        foreach (sb_q[i]) if (sb_q[i].accept < c && sb_q[i].start > c) occ++;
        if (occ < DEPTH) begin
            st = (c + 2 > last_end) ? c + 2 : last_end;
            sb_q.push_back('{accept: c, start: st, pat: ref_pattern(a)});
            last_end = st + H + G;
        end else begin
            ovf_q.push_back(c + 1);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] a);
        @(negedge clk);
        in_valid = v;
        alpha    = a;
        if (v && reset_n) model_input(cyc, a);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic monitor_cycle(input int unsigned c);
        logic [5:0] e_dots;
        logic       e_busy;
        logic       e_ovf;
        e_dots = '0;
        e_busy = 1'b0;
        e_ovf  = 1'b0;
        while (sb_q.size() > 0 && sb_q[0].start + H + G <= c) void'(sb_q.pop_front());
        if (sb_q.size() > 0) begin
            if (sb_q[0].accept < c) e_busy = 1'b1;
            if (sb_q[0].start <= c && c < sb_q[0].start + H) e_dots = sb_q[0].pat;
        end
        if (ovf_q.size() > 0 && ovf_q[0] == c) begin
            e_ovf = 1'b1;
            void'(ovf_q.pop_front());
        end
        check("dots", 32'(dots), 32'(e_dots));
        check("busy", 32'(busy), 32'(e_busy));
        check("overflow", 32'(overflow), 32'(e_ovf));
        check("drop_cnt", 32'(drop_cnt), exp_drop);
`ifdef BRAILLE_DROP_CNT_EN
        if (e_ovf && exp_drop < 255) exp_drop++;
`endif
    endtask

    initial begin
        wait (monitor_on);
        forever begin
            @(negedge clk);
            if (monitor_on) monitor_cycle(cyc);
        end
    end

    task automatic do_reset(input bit pulse_during);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_dots", 32'(dots), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        sb_q.delete();
        ovf_q.delete();
        last_end = 0;
        exp_drop = 0;
        if (pulse_during) drive(1'b1, 8'h42);
        idle(2);
        reset_n = 1'b1;
    endtask

    task automatic directed(input logic [7:0] a, input logic [5:0] exp_dots, input string name);
        drive(1'b1, a);
        drive(1'b0, 8'h00);
        @(negedge clk);
        check(name, 32'(dots), 32'(exp_dots));
        idle(H + G + 3);
        check({name, "_idle_busy"}, 32'(busy), 32'h0);
    endtask

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 3))
            0:       return 8'(8'h41 + $urandom_range(0, 25));
            1:       return 8'(8'h61 + $urandom_range(0, 25));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    logic [7:0] boundary_codes [8] = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};

    initial begin
        #1;
        do_reset(1'b0);
        monitor_on = 1'b1;

        directed(8'h41, 6'h01, "lat_A");
        directed(8'h63, 6'h09, "lat_c");
        directed(8'h5A, 6'h35, "lat_Z");
        directed(8'h31, 6'h00, "lat_1");

        foreach (boundary_codes[i]) begin
            drive(1'b1, boundary_codes[i]);
            idle(H + G + 2);
        end

        // Six back-to-back characters: five shown, one dropped.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h41 + i));
        idle(2);
`ifdef BRAILLE_DROP_CNT_EN
        check("burst_drop_cnt", 32'(drop_cnt), 32'd1);
`else
        check("burst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        idle(5 * (H + G) + 4);

        // Second character arriving mid-HOLD follows the gap directly.
        drive(1'b1, 8'h42);
        idle(3);
        drive(1'b1, 8'h43);
        idle(2 * (H + G) + 4);

        // Reset mid-HOLD with two characters queued.
        drive(1'b1, 8'h44);
        idle(3);
        drive(1'b1, 8'h45);
        drive(1'b1, 8'h46);
        idle(1);
        do_reset(1'b1);
        idle(30);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_dots", 32'(dots), 32'h0);

        // Sustained flood to drive drop_cnt into saturation.
        do_reset(1'b0);
        repeat (340) drive(1'b1, rand_code());
        idle(2);
`ifdef BRAILLE_DROP_CNT_EN
        check("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
`else
        check("sat_drop_cnt", 32'(drop_cnt), 32'h00);
`endif
        idle((DEPTH + 1) * (H + G) + 4);

        do_reset(1'b0);
        repeat (400) drive($urandom_range(0, 3) == 0, rand_code());
        idle((DEPTH + 2) * (H + G) + 4);
        check("final_busy", 32'(busy), 32'h0);

        monitor_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
